// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_pkg                                                              |
// | Shared definitions for the serial symmetric FIR: Q-format width      |
// | helpers and the sequencer state encoding.                            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // (x + x') * c : one growth bit from the pre-add, sign-by-sign product.
  function automatic int prod_w(input int nb_in, input int nb_coef);
    return nb_in + nb_coef + 1;
  endfunction

  function automatic int prod_frac(input int nb_in, input int nb_coef);
    return nb_in + nb_coef - 2;
  endfunction

  // Room for nhalf products without overflow.
  function automatic int acc_w(input int nb_in, input int nb_coef, input int nhalf);
    return prod_w(nb_in, nb_coef) + clog2(nhalf);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_round_fp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_round_fp                                                         |
// | Combinational fixed-point converter Q(NB_XI,NBF_XI) -> Q(NB_XO,      |
// | NBF_XO). Drops fractional bits (NBF_XI >= NBF_XO), then saturates.   |
// | FIR_SYM_SERIAL_ROUND_EN defined: round half up before dropping;      |
// | otherwise truncate toward minus infinity.                            |
// | Ports: i_data - signed input word, o_data - signed converted word.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sat_round_fp #(
  parameter int NB_XI  = 34,
  parameter int NBF_XI = 30,
  parameter int NB_XO  = 18,
  parameter int NBF_XO = 15
) (
  input  logic [NB_XI-1:0] i_data,
  output logic [NB_XO-1:0] o_data
);

  localparam int c_drop = NBF_XI - NBF_XO;
  // One guard bit so the rounding increment can never wrap.
  localparam int c_nb_s = NB_XI + 1 - c_drop;

  logic signed [NB_XI:0]    w_ext;
  logic signed [c_nb_s-1:0] w_scaled;

  assign w_ext = {i_data[NB_XI-1], i_data};

  generate
    if (c_drop > 0) begin : g_drop
      logic signed [NB_XI:0] w_biased;
`ifdef FIR_SYM_SERIAL_ROUND_EN
      localparam logic [NB_XI:0] c_half = {{NB_XI{1'b0}}, 1'b1} << (c_drop - 1);
      assign w_biased = w_ext + $signed(c_half);
`else
      assign w_biased = w_ext;
`endif
      assign w_scaled = c_nb_s'(w_biased >>> c_drop);
    end else begin : g_nodrop
      assign w_scaled = w_ext;
    end
  endgenerate

  generate
    if (c_nb_s > NB_XO) begin : g_sat
      logic [c_nb_s-NB_XO:0] w_top;
      logic                  w_ovf;
      // In range only when every bit above the output MSB copies the sign.
      assign w_top = w_scaled[c_nb_s-1:NB_XO-1];
      assign w_ovf = !((&w_top) || !(|w_top));
      always_comb begin
        o_data = w_scaled[NB_XO-1:0];
        if (w_ovf) begin
          o_data = w_scaled[c_nb_s-1] ? {1'b1, {(NB_XO-1){1'b0}}}
                                      : {1'b0, {(NB_XO-1){1'b1}}};
        end
      end
    end else begin : g_ext
      assign o_data = NB_XO'(w_scaled);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fir_sym_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_sym_serial                                                       |
// | Time-multiplexed symmetric FIR: one pre-adder and one multiplier     |
// | walk the NTAPS/2 coefficient pairs serially per accepted sample.     |
// | Output rounding selected by FIR_SYM_SERIAL_ROUND_EN (else truncate). |
// | Ports:                                                               |
// |   i_clk, i_rst_n (async, active low)                                 |
// |   i_data/i_valid/o_ready   - sample input handshake                  |
// |   i_coef_we/addr/data      - coefficient programming                 |
// |   o_data/o_valid           - filtered sample, one-cycle strobe       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fir_sym_serial
  import fir_pkg::*;
#(
  parameter int NB_INPUT   = 16,
  parameter int NB_COEF    = 16,
  parameter int NB_OUTPUT  = 18,
  parameter int NBF_OUTPUT = 15,
  parameter int NTAPS      = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NB_INPUT-1:0]               i_data,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic                              i_coef_we,
  input  logic [addr_w(NTAPS/2)-1:0]        i_coef_addr,
  input  logic [NB_COEF-1:0]                i_coef_data,
  output logic [NB_OUTPUT-1:0]              o_data,
  output logic                              o_valid
);

  localparam int c_nhalf    = NTAPS / 2;
  localparam int c_aw       = addr_w(c_nhalf);
  localparam int c_nb_pre   = NB_INPUT + 1;
  localparam int c_nb_prod  = prod_w(NB_INPUT, NB_COEF);
  localparam int c_nbf_prod = prod_frac(NB_INPUT, NB_COEF);
  localparam int c_nb_acc   = acc_w(NB_INPUT, NB_COEF, c_nhalf);

  fir_state_t r_state;
  fir_state_t w_state_next;

  logic signed [NB_INPUT-1:0]  r_x    [NTAPS];
  logic signed [NB_COEF-1:0]   r_coef [c_nhalf];
  logic        [c_aw-1:0]      r_k;
  logic signed [c_nb_acc-1:0]  r_acc;
  logic        [NB_OUTPUT-1:0] r_data;
  logic                        r_valid;

  logic signed [c_nb_pre-1:0]  w_pair;
  logic signed [NB_COEF-1:0]   w_coef;
  logic signed [c_nb_prod-1:0] w_prod;
  logic        [NB_OUTPUT-1:0] w_conv;
  logic                        w_ready;
  logic                        w_accept;
  logic                        w_last;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  assign w_last = (32'(r_k) == c_nhalf - 1);

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (i_valid) w_state_next = ST_MAC;
      end
      ST_MAC:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_accept = w_ready && i_valid;

  // ------------------------------------------------ shared pre-add / MAC
  // Coefficients are read live, so a write landing before its index is
  // consumed still affects the sample in flight.
  always_comb begin
    w_coef = '0;
    w_pair = '0;
    for (int i = 0; i < c_nhalf; i++) begin
      if (32'(r_k) == i) begin
        w_coef = r_coef[i];
        w_pair = c_nb_pre'(r_x[i]) + c_nb_pre'(r_x[NTAPS-1-i]);
      end
    end
  end

  assign w_prod = c_nb_prod'(w_pair) * c_nb_prod'(w_coef);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NTAPS; i++)   r_x[i]    <= '0;
      for (int i = 0; i < c_nhalf; i++) r_coef[i] <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_x[0] <= i_data;
        for (int i = 1; i < NTAPS; i++) r_x[i] <= r_x[i-1];
        r_acc <= '0;
        r_k   <= '0;
      end
      if (r_state == ST_MAC) begin
        r_acc <= r_acc + c_nb_acc'(w_prod);
        r_k   <= r_k + c_aw'(1);
      end
      if (r_state == ST_DONE) begin
        r_data  <= w_conv;
        r_valid <= 1'b1;
      end
      // Out-of-range addresses match no entry and are dropped.
      for (int i = 0; i < c_nhalf; i++) begin
        if (i_coef_we && (32'(i_coef_addr) == i)) r_coef[i] <= i_coef_data;
      end
    end
  end

  sat_round_fp #(
    .NB_XI  (c_nb_acc),
    .NBF_XI (c_nbf_prod),
    .NB_XO  (NB_OUTPUT),
    .NBF_XO (NBF_OUTPUT)
  ) u_conv (
    .i_data (r_acc),
    .o_data (w_conv)
  );

  assign o_ready = w_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fir_sym_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fir_sym_serial                                                    |
// | Self-checking bench: four instances (NTAPS = 2, 4, 6, 8) share clock |
// | and reset; expected outputs are queued at accept time and matched   |
// | on every o_valid.                                                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_fir_sym_serial;

`ifdef FIR_SYM_SERIAL_ROUND_EN
  localparam logic [17:0] MID = 18'h01D88;
`else
  localparam logic [17:0] MID = 18'h01D87;
`endif

  logic              clk;
  logic              rst_n;
  logic [3:0][15:0]  data;
  logic [3:0]        valid;
  logic [3:0]        ready;
  logic [3:0]        we;
  logic [3:0][1:0]   addr;
  logic [3:0][15:0]  cdata;
  logic [3:0][17:0]  odata;
  logic [3:0]        ovalid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NH = g + 1;
    localparam int AW = (NH > 2) ? 2 : 1;
    fir_sym_serial #(.NTAPS(2 * NH)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_data      (data[g]),
      .i_valid     (valid[g]),
      .o_ready     (ready[g]),
      .i_coef_we   (we[g]),
      .i_coef_addr (addr[g][AW-1:0]),
      .i_coef_data (cdata[g]),
      .o_data      (odata[g]),
      .o_valid     (ovalid[g])
    );
  end

  typedef struct packed {
    logic [1:0]  dut;
    logic [17:0] val;
  } exp_t;

  typedef struct {
    logic [15:0] din;
    logic [17:0] dout;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mx[4][8];
  int   mc[4][4];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h required 'h%0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] model_y(int d);
    longint acc;
    int     nt;
    acc = 0;
    nt  = 2 * (d + 1);
    for (int k = 0; k <= d; k++)
      acc += longint'(mc[d][k]) * longint'(mx[d][k] + mx[d][nt-1-k]);
`ifdef FIR_SYM_SERIAL_ROUND_EN
    acc += 16384;
`endif
    acc = acc >>> 15;
    if (acc > 131071) acc = 131071;
    else if (acc < -131072) acc = -131072;
    return 18'(acc);
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 8; i++) mx[d][i] = 0;
      for (int i = 0; i < 4; i++) mc[d][i] = 0;
    end
  endtask

  task automatic shift_model(int d, logic [15:0] s);
    for (int i = 7; i > 0; i--) mx[d][i] = mx[d][i-1];
    mx[d][0] = int'($signed(s));
  endtask

  task automatic wr(int d, int a, logic [15:0] v);
    @(negedge clk);
    we[d] = 1'b1; addr[d] = 2'(a); cdata[d] = v;
    @(negedge clk);
    we[d] = 1'b0;
    if (a <= d) mc[d][a] = int'($signed(v));
  endtask

  // Waits for ready, drives one sample, queues its expected output.
  task automatic send(int d, logic [15:0] s, bit use_tab, logic [17:0] tab);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready[d] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("ready_wait[dut%0d]", d), ready[d], 1);
    data[d] = s; valid[d] = 1'b1;
    @(posedge clk);
    #1 valid[d] = 1'b0;
    shift_model(d, s);
    q.push_back('{dut: 2'(d), val: (use_tab ? tab : model_y(d))});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_size", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 4; d++) begin
        if (ovalid[d]) begin
          chk($sformatf("unexpected_ovalid[dut%0d]", d), q.size() != 0, 1);
          if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("scoreboard_dut", d, e.dut);
            chk($sformatf("o_data[dut%0d]", d), odata[d], e.val);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab1[6];
    vec_t tab5[8];
    int   last_acc;
    int   low;

    tab1[0] = '{16'h4000, 18'h00278};
    tab1[1] = '{16'h0000, MID};
    tab1[2] = '{16'h0000, MID};
    tab1[3] = '{16'h0000, 18'h00278};
    tab1[4] = '{16'h0000, 18'h00000};
    tab1[5] = '{16'h0000, 18'h00000};

    tab5[0] = '{16'h4000, 18'h00278};
    tab5[1] = '{16'h0000, MID};
    tab5[2] = '{16'h0000, 18'h00800};
    tab5[3] = '{16'h0000, 18'h00800};
    tab5[4] = '{16'h0000, MID};
    tab5[5] = '{16'h0000, 18'h00278};
    tab5[6] = '{16'h0000, 18'h00000};
    tab5[7] = '{16'h0000, 18'h00000};

    rst_n = 1'b0;
    data = '0; valid = '0; we = '0; addr = '0; cdata = '0;
    clear_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_ready[dut%0d]", d), ready[d], 1);
      chk($sformatf("reset_ovalid[dut%0d]", d), ovalid[d], 0);
      chk($sformatf("reset_odata[dut%0d]", d), odata[d], 0);
    end
    rst_n = 1'b1;

    // Impulse response, NTAPS=4.
    wr(1, 0, 16'h04F0);
    wr(1, 1, 16'h3B0F);
    for (int i = 0; i < 6; i++) send(1, tab1[i].din, 1'b1, tab1[i].dout);
    drain();

    // NTAPS=6 with an out-of-range write that must not land anywhere.
    wr(2, 0, 16'h04F0);
    wr(2, 1, 16'h3B0F);
    wr(2, 2, 16'h1000);
    wr(2, 3, 16'h7FFF);
    for (int i = 0; i < 8; i++) send(2, tab5[i].din, 1'b1, tab5[i].dout);
    drain();

    // Saturation, NTAPS=8.
    for (int k = 0; k < 4; k++) wr(3, k, 16'h7FFF);
    for (int i = 0; i < 8; i++) send(3, 16'h7FFF, 1'b0, '0);
    drain();
    chk("sat_positive", odata[3], 18'h1FFFF);
    for (int i = 0; i < 8; i++) send(3, 16'h8000, 1'b0, '0);
    drain();
    chk("sat_negative", odata[3], 18'h20000);

    // Back-to-back handshake with i_valid held high and data changing.
    wr(1, 0, 16'h8123);
    wr(1, 1, 16'h6ABC);
    last_acc = -100;
    low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ovalid[1]) begin
        chk("ovalid_latency", i - 1 - last_acc, 3);
        chk("ready_with_ovalid", ready[1], 1);
      end
      if (!ready[1]) low++;
      else begin
        if (low != 0) chk("ready_low_cycles", low, 3);
        low = 0;
      end
      data[1] = 16'(i * 1234 + 77);
      valid[1] = 1'b1;
      if (ready[1]) begin
        last_acc = i;
        shift_model(1, data[1]);
        q.push_back('{dut: 2'd1, val: model_y(1)});
      end
    end
    @(negedge clk);
    valid[1] = 1'b0;
    drain();

    // Reset in the second MAC cycle.
    wr(1, 0, 16'h04F0);
    wr(1, 1, 16'h3B0F);
    @(negedge clk);
    data[1] = 16'h4000; valid[1] = 1'b1;
    @(posedge clk);
    #1 valid[1] = 1'b0; data[1] = '0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    clear_model();
    repeat (3) begin
      @(negedge clk);
      chk("ovalid_in_reset", ovalid[1], 0);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("ovalid_after_reset", ovalid[1], 0);
    end
    chk("odata_after_reset", odata[1], 0);
    chk("ready_after_reset", ready[1], 1);
    wr(1, 0, 16'h04F0);
    wr(1, 1, 16'h3B0F);
    for (int i = 0; i < 6; i++) send(1, tab1[i].din, 1'b1, tab1[i].dout);
    drain();

    // Random coefficients and samples on every tap count.
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < 3; r++) begin
        for (int w = 0; w < 4; w++) begin
          logic [15:0] cv;
          case ($urandom_range(0, 3))
            0:       cv = 16'h7FFF;
            1:       cv = 16'h8000;
            default: cv = 16'($urandom);
          endcase
          wr(d, int'($urandom_range(0, (d >= 2) ? 3 : 1)), cv);
        end
        for (int i = 0; i < 10; i++) begin
          logic [15:0] s;
          case ($urandom_range(0, 5))
            0:       s = 16'h7FFF;
            1:       s = 16'h8000;
            default: s = 16'($urandom);
          endcase
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(d, s, 1'b0, '0);
        end
        drain();
      end
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
